hd_program_loader: RTL

- Copies one program file from the simulated disk into instruction memory.
- Sits directly downstream of the simulated HD RAM, which has a 32-bit word, a 9-bit address and a registered read address, so data returns one cycle after the address.
- Scans the disk from word 0 for the N-th "begin file" marker, then streams every word up to and including the matching "end file" marker into instruction memory at a caller-supplied base.
- Jump targets inside a file are relative to its begin marker, so the marker itself is copied to offset 0.

---
 rtl/hd_program_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/hd_program_loader.sv
// Copies the N-th file from the simulated disk into instruction memory.
// Ports: clk/rst_n, start/prog_idx/im_base request, hd_addr/hd_q disk read,
//   im_we/im_addr/im_data write, busy/done/error, word_count/hd_start_addr.
module hd_program_loader #(
    parameter int DATA_WIDTH    = 32,
    parameter int HD_ADDR_WIDTH = 9,
    parameter int IM_ADDR_WIDTH = 10,
    parameter int IDX_WIDTH     = 4,
    parameter logic [5:0] OP_BEGIN = 6'b010101,
    parameter logic [5:0] OP_END   = 6'b010110,
    parameter logic [5:0] OP_HDEND = 6'b011000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [IDX_WIDTH-1:0]     prog_idx,
    input  logic [IM_ADDR_WIDTH-1:0] im_base,
    output logic [HD_ADDR_WIDTH-1:0] hd_addr,
    input  logic [DATA_WIDTH-1:0]    hd_q,
    output logic                     im_we,
    output logic [IM_ADDR_WIDTH-1:0] im_addr,
    output logic [DATA_WIDTH-1:0]    im_data,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [IM_ADDR_WIDTH-1:0] word_count,
    output logic [HD_ADDR_WIDTH-1:0] hd_start_addr
);

    typedef enum logic [1:0] {IDLE, SEEK, COPY} state_t;

    state_t                     state;
    logic [HD_ADDR_WIDTH-1:0]   file_cnt;
    logic [IDX_WIDTH-1:0]       idx;
    logic [IM_ADDR_WIDTH-1:0]   base;
    // Extra top bit flags an offset that no longer fits in memory.
    logic [IM_ADDR_WIDTH:0]     offset;
    logic                       vld;

    logic [5:0] op;
    logic       is_begin;
    logic       is_end;
    logic       is_hdend;
    logic       seek_hit;
    logic       copy_wr;
    logic       off_ovf;
    logic       wrap;
    logic       finish_ok;
    logic       abort;

    assign op       = hd_q[DATA_WIDTH-1 -: 6];
    assign is_begin = (op == OP_BEGIN);
    assign is_end   = (op == OP_END);
    assign is_hdend = (op == OP_HDEND);
    assign off_ovf  = offset[IM_ADDR_WIDTH];

    assign seek_hit = (state == SEEK) && vld && is_begin &&
                      (file_cnt == HD_ADDR_WIDTH'(idx));
    assign copy_wr  = (state == COPY) && vld && !is_hdend && !off_ovf;

    // hd_addr only reads 0 with vld set after it has wrapped; the word
    // on hd_q is then the last disk word, which is still processed.
    assign wrap      = vld && (hd_addr == '0);
    assign finish_ok = copy_wr && is_end;
    assign abort     = vld && (state != IDLE) &&
                       (is_hdend ||
                        ((state == COPY) && off_ovf) ||
                        (wrap && !finish_ok));

    assign im_we   = seek_hit || copy_wr;
    assign im_addr = base + offset[IM_ADDR_WIDTH-1:0];
    assign im_data = im_we ? hd_q : '0;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            hd_addr       <= '0;
            file_cnt      <= '0;
            idx           <= '0;
            base          <= '0;
            offset        <= '0;
            vld           <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            word_count    <= '0;
            hd_start_addr <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        hd_addr  <= '0;
                        file_cnt <= '0;
                        offset   <= '0;
                        vld      <= 1'b0;
                        error    <= 1'b0;
                        idx      <= prog_idx;
                        base     <= im_base;
                        state    <= SEEK;
                    end
                end
                SEEK: begin
                    hd_addr <= hd_addr + HD_ADDR_WIDTH'(1);
                    vld     <= 1'b1;
                    if (seek_hit) begin
                        hd_start_addr <= hd_addr - HD_ADDR_WIDTH'(1);
                        offset        <= (IM_ADDR_WIDTH+1)'(1);
                        state         <= COPY;
                    end else if (vld && is_begin) begin
                        file_cnt <= file_cnt + HD_ADDR_WIDTH'(1);
                    end
                end
                COPY: begin
                    hd_addr <= hd_addr + HD_ADDR_WIDTH'(1);
                    vld     <= 1'b1;
                    if (copy_wr) begin
                        offset <= offset + (IM_ADDR_WIDTH+1)'(1);
                    end
                    if (finish_ok) begin
                        word_count <= offset[IM_ADDR_WIDTH-1:0] +
                                      IM_ADDR_WIDTH'(1);
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (abort) begin
                error <= 1'b1;
                done  <= 1'b1;
                state <= IDLE;
            end
        end
    end

endmodule
